threshold_pack_sched: RTL and testbench

Sequencing controller for the binarization datapath. It walks the four pixel lanes in fixed order 0,1,2,3,0,1,2,3 and consumes one grayscale pixel per lane turn through a valid/ready handshake. Each pixel is compared against that lane's programmable threshold, and the eight resulting bits are packed into one byte. Bytes go out on a backpressured stream until a programmed frame length is reached. It sits between the four pixel-source lanes and the byte sink (memory writer or UART).

---
 rtl/threshold_pack_sched.sv | 157 +++++++++++++++
 tb/tb_threshold_pack_sched.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/threshold_pack_sched.sv
// rtl/threshold_pack_sched.sv - four-lane threshold binarizer packing eight pixel bits per output byte
// Lanes are served round-robin 0..3 twice per byte; bytes stream out until the frame length is reached.
module threshold_pack_sched #(
  parameter int FRAME_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_we,
  input  logic [1:0]         cfg_addr,
  input  logic [7:0]         cfg_data,
  input  logic [FRAME_W-1:0] frame_bytes,
  input  logic               start,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  input  logic [3:0]         pix_valid,
  input  logic [31:0]        pix_data,
  output logic [3:0]         pix_ready,
  output logic [1:0]         lane_sel,
  output logic [7:0]         packed_data,
  output logic               packed_valid,
  input  logic               packed_ready
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EMIT  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [FRAME_W-1:0] CNT_ONE  = {{(FRAME_W-1){1'b0}}, 1'b1};
  localparam logic [7:0]         THR_INIT = 8'd128;

  state_e             state_q, state_d;
  logic [3:0][7:0]    thr_q, thr_d;
  logic [FRAME_W-1:0] frame_len_q, frame_len_d;
  logic [FRAME_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic [7:0]         buf_q, buf_d;
  logic [7:0]         pdata_q, pdata_d;

  logic [1:0] lane;
  logic [7:0] cur_pix;
  logic [7:0] cur_thr;
  logic       cur_bit;
  logic       start_ok;
  logic       pix_fire;
  logic       byte_fire;
  logic       last_byte;
  logic       cfg_open;

  assign lane      = bit_idx_q[1:0];
  assign cur_pix   = pix_data[{lane, 3'b000} +: 8];
  assign cur_thr   = thr_q[lane];
  assign cur_bit   = (cur_pix >= cur_thr);
  assign start_ok  = (state_q == S_IDLE) && start && !abort;
  assign pix_fire  = (state_q == S_FETCH) && pix_valid[lane] && !abort;
  assign byte_fire = (state_q == S_EMIT) && packed_ready && !abort;
  assign last_byte = (byte_cnt_q == frame_len_q - CNT_ONE);
  assign cfg_open  = (state_q == S_IDLE) || (state_q == S_DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // abort overrides every transition, including a simultaneous start
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (start) state_d = (frame_bytes == '0) ? S_DONE : S_FETCH;
        S_FETCH: if (pix_fire && (bit_idx_q == 3'd7)) state_d = S_EMIT;
        S_EMIT:  if (byte_fire) state_d = last_byte ? S_DONE : S_FETCH;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy         = 1'b0;
    done         = 1'b0;
    packed_valid = 1'b0;
    pix_ready    = 4'b0000;
    case (state_q)
      S_FETCH: begin
        busy      = 1'b1;
        pix_ready = 4'b0001 << lane;
      end
      S_EMIT: begin
        busy         = 1'b1;
        packed_valid = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign lane_sel    = lane;
  assign packed_data = pdata_q;

  always_comb begin
    thr_d       = thr_q;
    frame_len_d = frame_len_q;
    byte_cnt_d  = byte_cnt_q;
    bit_idx_d   = bit_idx_q;
    buf_d       = buf_q;
    pdata_d     = pdata_q;
    if (cfg_we && cfg_open) begin
      thr_d[cfg_addr] = cfg_data;
    end
    if (start_ok) begin
      frame_len_d = frame_bytes;
      byte_cnt_d  = '0;
      bit_idx_d   = 3'd0;
      buf_d       = 8'h00;
    end
    if (pix_fire) begin
      buf_d[bit_idx_q] = cur_bit;
      bit_idx_d        = bit_idx_q + 3'd1;
      if (bit_idx_q == 3'd7) begin
        pdata_d = {cur_bit, buf_q[6:0]};
      end
    end
    if (byte_fire) begin
      byte_cnt_d = byte_cnt_q + CNT_ONE;
      bit_idx_d  = 3'd0;
      buf_d      = 8'h00;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      thr_q       <= {4{THR_INIT}};
      frame_len_q <= '0;
      byte_cnt_q  <= '0;
      bit_idx_q   <= 3'd0;
      buf_q       <= 8'h00;
      pdata_q     <= 8'h00;
    end else begin
      thr_q       <= thr_d;
      frame_len_q <= frame_len_d;
      byte_cnt_q  <= byte_cnt_d;
      bit_idx_q   <= bit_idx_d;
      buf_q       <= buf_d;
      pdata_q     <= pdata_d;
    end
  end

endmodule

// File: tb/tb_threshold_pack_sched.sv
// tb/tb_threshold_pack_sched.sv - scoreboard bench for threshold_pack_sched
module tb_threshold_pack_sched;

  localparam int FW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          cfg_we;
  logic [1:0]    cfg_addr;
  logic [7:0]    cfg_data;
  logic [FW-1:0] frame_bytes;
  logic          start;
  logic          abort;
  logic          busy;
  logic          done;
  logic [3:0]    pix_valid;
  logic [31:0]   pix_data;
  logic [3:0]    pix_ready;
  logic [1:0]    lane_sel;
  logic [7:0]    packed_data;
  logic          packed_valid;
  logic          packed_ready;

  threshold_pack_sched #(.FRAME_W(FW)) dut (
    .clk          (clk),
    .reset        (reset),
    .cfg_we       (cfg_we),
    .cfg_addr     (cfg_addr),
    .cfg_data     (cfg_data),
    .frame_bytes  (frame_bytes),
    .start        (start),
    .abort        (abort),
    .busy         (busy),
    .done         (done),
    .pix_valid    (pix_valid),
    .pix_data     (pix_data),
    .pix_ready    (pix_ready),
    .lane_sel     (lane_sel),
    .packed_data  (packed_data),
    .packed_valid (packed_valid),
    .packed_ready (packed_ready)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail = 0;
  int         hs_cnt = 0;
  bit         ready_seen = 0;
  bit         done_seen = 0;
  logic [3:0] hold = 4'b0000;
  logic [7:0] lane_q [4][$];
  logic [7:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // pixel sources: each lane offers the head of its queue unless held
  initial begin
    logic [3:0] fire;
    pix_valid = 4'b0000;
    pix_data  = 32'h0;
    forever begin
      @(negedge clk);
      fire = pix_valid & pix_ready;
      @(posedge clk);
      #2;
      for (int n = 0; n < 4; n++) begin
        if (fire[n] && lane_q[n].size() > 0) void'(lane_q[n].pop_front());
        pix_valid[n]       = (lane_q[n].size() > 0) && !hold[n];
        pix_data[8*n +: 8] = (lane_q[n].size() > 0) ? lane_q[n][0] : 8'h00;
      end
    end
  end

  // scoreboard monitor
  always @(negedge clk) begin
    if (pix_ready != 4'b0000) ready_seen = 1;
    if (done) done_seen = 1;
    if (packed_valid && packed_ready) begin
      hs_cnt++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected: got %02h required no byte", packed_data);
      end else begin
        check("sb_byte", packed_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic push4(input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] a2, input logic [7:0] a3);
    lane_q[0].push_back(a0);
    lane_q[1].push_back(a1);
    lane_q[2].push_back(a2);
    lane_q[3].push_back(a3);
  endtask

  // bit k of v becomes pixel k on lane k%4; uses the 127/128 boundary around thr=128
  task automatic queue_byte(input logic [7:0] v, input bit push_exp);
    logic [7:0] px;
    for (int k = 0; k < 8; k++) begin
      if (v[k]) px = (k % 2 == 1) ? 8'd255 : 8'd128;
      else      px = (k % 2 == 1) ? 8'd0   : 8'd127;
      lane_q[k % 4].push_back(px);
    end
    if (push_exp) exp_q.push_back(v);
  endtask

  task automatic write_thr(input logic [1:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    cfg_we = 1; cfg_addr = a; cfg_data = d;
    @(posedge clk); #1;
    cfg_we = 0;
  endtask

  task automatic start_frame(input logic [FW-1:0] n);
    @(posedge clk); #1;
    frame_bytes = n; start = 1;
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic wait_done(input string name, input int exp_d);
    int d;
    bit seen;
    d = 1;
    seen = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        break;
      end
      d++;
    end
    check({name, "_done_seen"}, seen, 1);
    if (seen) begin
      if (exp_d >= 0) check({name, "_done_cycle"}, d, exp_d);
      @(negedge clk);
      check({name, "_done_pulse"}, done, 0);
    end
  endtask

  task automatic wait_valid(input string name);
    bit seen;
    seen = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (packed_valid) begin
        seen = 1;
        break;
      end
    end
    check({name, "_valid_seen"}, seen, 1);
  endtask

  initial begin
    int  hs0;
    int  q0, q1, q3;
    bit  ok;
    bit  seen;
    logic [7:0] bp_exp [3];

    reset = 0; cfg_we = 0; cfg_addr = 0; cfg_data = 0;
    frame_bytes = 0; start = 0; abort = 0; packed_ready = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pix_ready", pix_ready, 0);
    check("rst_lane_sel", lane_sel, 0);
    check("rst_packed_data", packed_data, 0);
    check("rst_packed_valid", packed_valid, 0);
    @(posedge clk); #1;
    reset = 1;

    // thresholds 10,20,30,40: threshold-1 gives 0, threshold gives 1
    write_thr(0, 8'd10); write_thr(1, 8'd20); write_thr(2, 8'd30); write_thr(3, 8'd40);
    push4(9, 19, 29, 39); push4(9, 19, 29, 39); exp_q.push_back(8'h00);
    start_frame(1);
    wait_done("thr_below", -1);
    push4(10, 20, 30, 40); push4(10, 20, 30, 40); exp_q.push_back(8'hFF);
    start_frame(1);
    wait_done("thr_equal", -1);
    for (int n = 0; n < 4; n++) write_thr(n[1:0], 8'd128);

    // lane-alternating pattern and done latency
    push4(200, 200, 200, 200); push4(0, 0, 0, 0); exp_q.push_back(8'h0F);
    start_frame(1);
    wait_done("alt", 10);

    // backpressure on every byte
    bp_exp[0] = 8'h81; bp_exp[1] = 8'h7E; bp_exp[2] = 8'h55;
    for (int b = 0; b < 3; b++) queue_byte(bp_exp[b], 1);
    packed_ready = 0;
    hs0 = hs_cnt;
    start_frame(3);
    for (int b = 0; b < 3; b++) begin
      wait_valid("bp");
      ok = 1;
      repeat (5) begin
        @(negedge clk);
        if (!(packed_valid && packed_data == bp_exp[b] && pix_ready == 4'b0000)) ok = 0;
      end
      check("bp_hold_stable", ok, 1);
      @(posedge clk); #1;
      packed_ready = 1;
      @(posedge clk); #1;
      packed_ready = 0;
    end
    wait_done("bp", -1);
    check("bp_handshakes", hs_cnt - hs0, 3);
    packed_ready = 1;

    // lane 2 stalls at bit_idx 2 while other lanes stay valid
    hold = 4'b0100;
    queue_byte(8'hE7, 1);
    start_frame(1);
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (busy && lane_sel == 2) begin
        seen = 1;
        break;
      end
    end
    check("stall_reached", seen, 1);
    q0 = lane_q[0].size(); q1 = lane_q[1].size(); q3 = lane_q[3].size();
    ok = 1;
    repeat (7) begin
      @(negedge clk);
      if (!(lane_sel == 2 && pix_ready == 4'b0100 && pix_valid[0] && pix_valid[3])) ok = 0;
      if (lane_q[0].size() != q0 || lane_q[1].size() != q1 || lane_q[3].size() != q3) ok = 0;
    end
    check("stall_hold", ok, 1);
    @(posedge clk); #1;
    hold = 4'b0000;
    wait_done("stall", -1);

    // abort at bit_idx 5 of byte 1
    queue_byte(8'h5A, 1);
    push4(200, 200, 200, 200); lane_q[0].push_back(8'd200);
    start_frame(4);
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy && pix_ready == 4'b0010 && lane_q[0].size() == 0 && lane_q[1].size() == 0
          && lane_q[2].size() == 0 && lane_q[3].size() == 0) begin
        seen = 1;
        break;
      end
    end
    check("abort_reached", seen, 1);
    @(posedge clk); #1;
    abort = 1;
    @(posedge clk); #1;
    check("abort_busy", busy, 0);
    check("abort_packed_valid", packed_valid, 0);
    check("abort_pix_ready", pix_ready, 0);
    abort = 0;
    done_seen = 0;
    repeat (4) @(negedge clk);
    check("abort_no_done", done_seen, 0);
    queue_byte(8'hC3, 1);
    start_frame(1);
    wait_done("after_abort", 10);

    // zero-length frame
    ready_seen = 0;
    hs0 = hs_cnt;
    start_frame(0);
    wait_done("zero", 1);
    check("zero_no_pix_ready", ready_seen, 0);
    check("zero_no_bytes", hs_cnt - hs0, 0);

    // threshold writes during busy are ignored
    push4(200, 200, 100, 200); push4(200, 200, 100, 200); exp_q.push_back(8'hBB);
    start_frame(1);
    @(posedge clk); #1;
    cfg_we = 1; cfg_addr = 2; cfg_data = 8'd0;
    @(posedge clk); #1;
    cfg_addr = 3; cfg_data = 8'd255;
    @(posedge clk); #1;
    cfg_we = 0;
    wait_done("cfg_busy", -1);

    // reset during EMIT
    packed_ready = 0;
    queue_byte(8'h3C, 0);
    start_frame(1);
    wait_valid("rst_emit");
    check("rst_emit_data", packed_data, 8'h3C);
    #2;
    reset = 0;
    #1;
    check("rst_emit_valid", packed_valid, 0);
    check("rst_emit_busy", busy, 0);
    check("rst_emit_pdata", packed_data, 0);
    @(posedge clk); #1;
    reset = 1;
    packed_ready = 1;
    for (int n = 0; n < 4; n++) lane_q[n].delete();

    // thresholds are back at 128 after reset
    queue_byte(8'h96, 1);
    start_frame(1);
    wait_done("post_reset", 10);
    check("sb_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
